gray_quadrature_decoder: RTL and testbench

Decodes the 2-bit Gray-code output of a mechanical quadrature rotary encoder (channels A/B) into a wrapping position count with step and direction indications. It synchronises and debounces the raw board inputs, tracks Gray-code phase transitions, and flags illegal two-bit jumps. It sits between the board switch/GPIO pins and the binary/Gray display path: `position` feeds the same seven-segment digit split used for the converter outputs.

---
 rtl/gray_quadrature_decoder.sv | 150 +++++++++++++++
 tb/tb_gray_quadrature_decoder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_quadrature_decoder.sv
// Quadrature encoder front end: synchronises and debounces channels A/B, then turns
// qualified Gray-code phase changes into a wrapping position count with step/dir/err.
module gray_quadrature_decoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_WIDTH       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 quad_a,
  input  logic                 quad_b,
  input  logic                 clear,
  output logic [CNT_WIDTH-1:0] position,
  output logic                 step,
  output logic                 dir,
  output logic                 err,
  output logic                 err_flag
);
  localparam int QW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [QW-1:0] QUAL_TARGET = QW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_QUAL} state_t;

  state_t               state_reg, state_next;
  logic [1:0]           a_sync_reg, b_sync_reg;
  logic [1:0]           g_sync;
  logic [1:0]           g_filt_reg, g_filt_next;
  logic [1:0]           g_cand_reg, g_cand_next;
  logic [QW-1:0]        qual_cnt_reg, qual_cnt_next, cnt_inc;
  logic                 accept_event;
  logic [1:0]           p_old, p_new, delta;
  logic [CNT_WIDTH-1:0] position_next;
  logic                 step_next, dir_next, err_next, err_flag_next;

  // Bit 0 is the metastability-catching stage, bit 1 the synchronised output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sync_reg <= '0;
      b_sync_reg <= '0;
    end else begin
      a_sync_reg <= {a_sync_reg[0], quad_a};
      b_sync_reg <= {b_sync_reg[0], quad_b};
    end
  end

  assign g_sync = {a_sync_reg[1], b_sync_reg[1]};

  // Phase p = {a, a^b} turns the Gray sequence 00,01,11,10 into 0..3.
  assign p_old = {g_filt_reg[1], ^g_filt_reg};
  assign p_new = {g_sync[1], ^g_sync};
  assign delta = p_new - p_old;

  always_comb begin
    state_next    = state_reg;
    g_filt_next   = g_filt_reg;
    g_cand_next   = g_cand_reg;
    qual_cnt_next = qual_cnt_reg;
    accept_event  = 1'b0;

    // A candidate that holds steady keeps counting; anything new restarts at 1.
    if (state_reg != S_IDLE && qual_cnt_reg != '0 && g_sync == g_cand_reg)
      cnt_inc = qual_cnt_reg + 1'b1;
    else
      cnt_inc = QW'(1);

    case (state_reg)
      S_INIT: begin
        g_cand_next   = g_sync;
        qual_cnt_next = cnt_inc;
        if (cnt_inc == QUAL_TARGET) begin
          g_filt_next   = g_sync;
          qual_cnt_next = '0;
          state_next    = S_IDLE;
        end
      end
      default: begin
        if (g_sync == g_filt_reg) begin
          qual_cnt_next = '0;
          state_next    = S_IDLE;
        end else begin
          g_cand_next   = g_sync;
          qual_cnt_next = cnt_inc;
          if (cnt_inc == QUAL_TARGET) begin
            accept_event  = 1'b1;
            g_filt_next   = g_sync;
            qual_cnt_next = '0;
            state_next    = S_IDLE;
          end else begin
            state_next = S_QUAL;
          end
        end
      end
    endcase
  end

  always_comb begin
    position_next = position;
    dir_next      = dir;
    err_flag_next = err_flag;
    step_next     = 1'b0;
    err_next      = 1'b0;
    if (accept_event) begin
      case (delta)
        2'd1: begin
          position_next = position + 1'b1;
          dir_next      = 1'b1;
          step_next     = 1'b1;
        end
        2'd3: begin
          position_next = position - 1'b1;
          dir_next      = 1'b0;
          step_next     = 1'b1;
        end
        2'd2: begin
          err_next      = 1'b1;
          err_flag_next = 1'b1;
        end
        default: ;
      endcase
    end
    // Clear wins over a same-cycle count or error; the pulses still go out.
    if (clear) begin
      position_next = '0;
      err_flag_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_INIT;
      g_filt_reg   <= 2'b00;
      g_cand_reg   <= 2'b00;
      qual_cnt_reg <= '0;
      position     <= '0;
      step         <= 1'b0;
      dir          <= 1'b0;
      err          <= 1'b0;
      err_flag     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      g_filt_reg   <= g_filt_next;
      g_cand_reg   <= g_cand_next;
      qual_cnt_reg <= qual_cnt_next;
      position     <= position_next;
      step         <= step_next;
      dir          <= dir_next;
      err          <= err_next;
      err_flag     <= err_flag_next;
    end
  end
endmodule

// File: tb/tb_gray_quadrature_decoder.sv
// Directed bench for gray_quadrature_decoder: expected events are queued when inputs
// change and matched against step/err pulses, including the cycle they arrive on.
module tb_gray_quadrature_decoder;
  localparam int DEB = 4;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          quad_a = 1'b0;
  logic          quad_b = 1'b0;
  logic          clear = 1'b0;
  logic [CW-1:0] position;
  logic          step, dir, err, err_flag;

  gray_quadrature_decoder #(.DEBOUNCE_CYCLES(DEB), .CNT_WIDTH(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .quad_a   (quad_a),
    .quad_b   (quad_b),
    .clear    (clear),
    .position (position),
    .step     (step),
    .dir      (dir),
    .err      (err),
    .err_flag (err_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] pos;
    logic          step;
    logic          err;
    logic          dir;
    logic          eflag;
    int            cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  compared = 0;
  int  mismatched = 0;
  int  cyc = 0;

  logic [1:0]    m_code;
  logic [CW-1:0] m_pos;
  logic          m_dir, m_eflag;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [1:0] ph(input logic [1:0] c);
    case (c)
      2'b00:   ph = 2'd0;
      2'b01:   ph = 2'd1;
      2'b11:   ph = 2'd2;
      default: ph = 2'd3;
    endcase
  endfunction

  function automatic logic [1:0] code_of(input logic [1:0] p);
    case (p)
      2'd0:    code_of = 2'b00;
      2'd1:    code_of = 2'b01;
      2'd2:    code_of = 2'b11;
      default: code_of = 2'b10;
    endcase
  endfunction

  // Event checker: every step/err pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && (step || err)) begin
      check("step_err_exclusive", {31'b0, step & err}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_event", {30'b0, step, err}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("ev_step",  {31'b0, step}, {31'b0, mon_e.step});
        check("ev_err",   {31'b0, err}, {31'b0, mon_e.err});
        check("ev_dir",   {31'b0, dir}, {31'b0, mon_e.dir});
        check("ev_pos",   {28'b0, position}, {28'b0, mon_e.pos});
        check("ev_eflag", {31'b0, err_flag}, {31'b0, mon_e.eflag});
        check("ev_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic drive(input logic [1:0] v);
    @(posedge clk);
    #1 {quad_a, quad_b} = v;
  endtask

  // Move to raw code v, queue the event the rules predict, optionally clear on the accept edge.
  task automatic move(input logic [1:0] v, input int hold, input logic clr_at_accept);
    ev_t        e;
    logic [1:0] d;
    d      = ph(v) - ph(m_code);
    e.step = 1'b0;
    e.err  = 1'b0;
    if (d == 2'd1) begin
      m_pos = m_pos + 1'b1; m_dir = 1'b1; e.step = 1'b1;
    end else if (d == 2'd3) begin
      m_pos = m_pos - 1'b1; m_dir = 1'b0; e.step = 1'b1;
    end else if (d == 2'd2) begin
      m_eflag = 1'b1; e.err = 1'b1;
    end
    if (clr_at_accept) begin
      m_pos = '0; m_eflag = 1'b0;
    end
    m_code = v;
    drive(v);
    e.cyc   = cyc + 2 + DEB;
    e.pos   = m_pos;
    e.dir   = m_dir;
    e.eflag = m_eflag;
    exp_q.push_back(e);
    if (clr_at_accept) begin
      repeat (1 + DEB) @(posedge clk);
      #1 clear = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
      repeat (hold - 2 - DEB) @(posedge clk);
    end else begin
      repeat (hold) @(posedge clk);
    end
  endtask

  task automatic up(input int hold);
    move(code_of(ph(m_code) + 2'd1), hold, 1'b0);
  endtask

  task automatic down(input int hold);
    move(code_of(ph(m_code) - 2'd1), hold, 1'b0);
  endtask

  task automatic glitch(input logic [1:0] v, input int n);
    drive(v);
    repeat (n - 1) @(posedge clk);
    drive(m_code);
    repeat (10) @(posedge clk);
  endtask

  task automatic clear_pulse();
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    m_pos   = '0;
    m_eflag = 1'b0;
  endtask

  task automatic settle(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_pending"}, exp_q.size(), 32'd0);
    @(negedge clk);
    check({tag, "_pos"},   {28'b0, position}, {28'b0, m_pos});
    check({tag, "_eflag"}, {31'b0, err_flag}, {31'b0, m_eflag});
    check({tag, "_dir"},   {31'b0, dir}, {31'b0, m_dir});
  endtask

  initial begin
    {quad_a, quad_b} = 2'b11;
    m_code = 2'b11; m_pos = '0; m_dir = 1'b0; m_eflag = 1'b0;

    // Reset with 11 held; INIT adopts it silently.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_pos",   {28'b0, position}, 32'd0);
    check("reset_step",  {31'b0, step}, 32'd0);
    check("reset_err",   {31'b0, err}, 32'd0);
    check("reset_dir",   {31'b0, dir}, 32'd0);
    check("reset_eflag", {31'b0, err_flag}, 32'd0);
    repeat (8) @(posedge clk);
    settle("init");

    // 11 was taken as the filtered code: 11->10 counts up.
    up(10);
    up(10);
    clear_pulse();
    settle("pre_up");

    repeat (4) up(10);
    settle("up4");

    clear_pulse();
    down(10);
    settle("down_wrap");
    down(10);
    down(10);
    down(10);
    settle("down3");

    glitch(2'b01, 3);
    settle("glitch");

    drive(2'b01);
    repeat (2) @(posedge clk);
    move(2'b11, 10, 1'b0);
    settle("glitch_then_illegal");

    up(10);
    settle("eflag_sticky");
    clear_pulse();
    repeat (5) up(10);
    settle("pos5");
    move(2'b11, 10, 1'b0);
    settle("illegal");
    clear_pulse();
    settle("clear");
    move(2'b10, 10, 1'b1);
    settle("clear_with_step");
    up(10);
    settle("pre_reset");

    // Reset while a 00->01 candidate sits at count 2.
    drive(2'b01);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_pos",   {28'b0, position}, 32'd0);
    check("midreset_dir",   {31'b0, dir}, 32'd0);
    check("midreset_step",  {31'b0, step}, 32'd0);
    check("midreset_err",   {31'b0, err}, 32'd0);
    check("midreset_eflag", {31'b0, err_flag}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    m_code = 2'b01; m_pos = '0; m_dir = 1'b0; m_eflag = 1'b0;
    repeat (10) @(posedge clk);
    settle("post_reset");
    up(10);
    settle("post_reset_up");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
